// File: rtl/reg_file_sb.sv
// Decode-stage register file: NRD combinational read ports with write forwarding,
// one write port, optional hardwired zero register, pending-write scoreboard and a registered debug tap.
module reg_file_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_en,
  output logic [NRD*DW-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                stall,
  output logic [2**AW-1:0]    busy,
  input  logic [AW-1:0]       dbg_sel,
  output logic [DW-1:0]       dbg_data
);

  localparam int DEPTH = 2**AW;
  localparam bit ZR    = (ZERO_R0 != 0);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DW-1:0]    r_dbg;

  logic             w_wr_ok;
  logic [DEPTH-1:0] w_set_vec;
  logic [DEPTH-1:0] w_clr_vec;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [NRD-1:0]   w_hz;

  // Writes to the zero register are dropped so r_mem[0] stays 0 after reset.
  assign w_wr_ok = wr_en & ~(ZR & (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < DEPTH; n++) r_mem[n] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (iss_en) w_set_vec[iss_addr] = 1'b1;
    if (wr_en)  w_clr_vec[wr_addr]  = 1'b1;
    // A new producer issued in the same cycle as the old one's writeback keeps the register busy.
    w_busy_nxt = (r_busy & ~w_clr_vec) | w_set_vec;
    if (ZR) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign busy = r_busy;

  genvar g;
  for (g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_fwd;
    logic          w_zero;

    assign w_ra   = rd_addr[g*AW +: AW];
    assign w_fwd  = wr_en & (wr_addr == w_ra);
    assign w_zero = ZR & (w_ra == '0);
    assign rd_data[g*DW +: DW] = w_zero ? '0 : (w_fwd ? wr_data : r_mem[w_ra]);
    // A same-cycle writeback is forwarded, so it resolves the hazard without stalling.
    assign w_hz[g] = rd_en[g] & r_busy[w_ra] & ~w_fwd;
  end

  assign stall = |w_hz;

  always_ff @(posedge clk) begin
    if (reset)                    r_dbg <= '0;
    else if (ZR && dbg_sel == '0) r_dbg <= '0;
    else                          r_dbg <= r_mem[dbg_sel];
  end

  assign dbg_data = r_dbg;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expectations queued at drive time, popped and asserted at sample time.
module tb_reg_file_sb;

  localparam int DW = 32, AW = 5, NRD = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_en;
  logic [NRD*DW-1:0]   rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                stall;
  logic [2**AW-1:0]    busy;
  logic [AW-1:0]       dbg_sel;
  logic [DW-1:0]       dbg_data;

  reg_file_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .stall(stall), .busy(busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  string       tq[$];
  logic [63:0] vq[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic exp_push(input string tag, input logic [63:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    n_checks++;
    if (vq.size() == 0) begin
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      t = tq.pop_front();
      e = vq.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  // Advance across one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] a5(input int v);
    return AW'(v);
  endfunction

  initial begin
    reset = 1'b1; rd_addr = '0; rd_en = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; dbg_sel = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Reset state: every address reads 0 on both ports, no stall, no busy, debug 0.
    exp_push("rst_busy", 64'h0);
    exp_push("rst_dbg", 64'h0);
    #1;
    sb_check(64'(busy));
    sb_check(64'(dbg_data));
    rd_en = 2'b11;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a5(a), a5(a)};
      exp_push($sformatf("rst_rd_a%0d", a), 64'h0);
      exp_push($sformatf("rst_stall_a%0d", a), 64'h0);
      #1;
      sb_check(64'(rd_data));
      sb_check(64'(stall));
    end
    rd_en = 2'b00;
    tick();

    // Plain write, then read back next cycle.
    wr_en = 1'b1; wr_addr = a5(5); wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_addr = {a5(0), a5(5)};
    exp_push("rd_r5", 64'hDEADBEEF);
    #1;
    sb_check(64'(rd_data[31:0]));

    // Same-cycle forwarding on port 1, port 0 still reading r5.
    wr_en = 1'b1; wr_addr = a5(7); wr_data = 32'h12345678; rd_addr = {a5(7), a5(5)};
    exp_push("fwd_r7", 64'h12345678);
    exp_push("fwd_p0_r5", 64'hDEADBEEF);
    #1;
    sb_check(64'(rd_data[63:32]));
    sb_check(64'(rd_data[31:0]));
    tick();
    wr_en = 1'b0; rd_addr = {a5(7), a5(7)};
    exp_push("both_r7", {32'h12345678, 32'h12345678});
    #1;
    sb_check(64'(rd_data));

    // Zero register: writes dropped, never forwarded, never busy.
    wr_en = 1'b1; wr_addr = a5(0); wr_data = 32'hFFFFFFFF; rd_addr = {a5(0), a5(0)};
    exp_push("r0_fwd", 64'h0);
    #1;
    sb_check(64'(rd_data));
    tick();
    wr_en = 1'b0; dbg_sel = a5(0);
    exp_push("r0_rd", 64'h0);
    #1;
    sb_check(64'(rd_data));
    iss_en = 1'b1; iss_addr = a5(0);
    tick();
    iss_en = 1'b0;
    exp_push("r0_dbg", 64'h0);
    exp_push("r0_busy", 64'h0);
    #1;
    sb_check(64'(dbg_data));
    sb_check(64'(busy));

    // Scoreboard hazard on r9 held for three cycles, cleared by a same-cycle writeback.
    iss_en = 1'b1; iss_addr = a5(9);
    tick();
    iss_en = 1'b0; rd_en = 2'b01; rd_addr = {a5(0), a5(9)};
    for (int c = 0; c < 3; c++) begin
      exp_push($sformatf("stall_r9_c%0d", c), 64'h1);
      exp_push($sformatf("busy_r9_c%0d", c), 64'h200);
      #1;
      sb_check(64'(stall));
      sb_check(64'(busy));
      tick();
    end
    wr_en = 1'b1; wr_addr = a5(9); wr_data = 32'hA5A5A5A5;
    exp_push("wb_stall", 64'h0);
    exp_push("wb_fwd", 64'hA5A5A5A5);
    #1;
    sb_check(64'(stall));
    sb_check(64'(rd_data[31:0]));
    tick();
    wr_en = 1'b0;
    exp_push("r9_busy_clr", 64'h0);
    exp_push("r9_stall_clr", 64'h0);
    exp_push("r9_rd", 64'hA5A5A5A5);
    #1;
    sb_check(64'(busy));
    sb_check(64'(stall));
    sb_check(64'(rd_data[31:0]));
    rd_en = 2'b00;

    // Set wins over clear on r4; a disabled port never stalls, an enabled one does.
    iss_en = 1'b1; iss_addr = a5(4); wr_en = 1'b1; wr_addr = a5(4); wr_data = 32'h44;
    tick();
    iss_en = 1'b0; wr_en = 1'b0; rd_en = 2'b00; rd_addr = {a5(4), a5(0)};
    exp_push("r4_busy", 64'h10);
    exp_push("r4_noen_stall", 64'h0);
    #1;
    sb_check(64'(busy));
    sb_check(64'(stall));
    rd_en = 2'b10;
    exp_push("r4_en_stall", 64'h1);
    #1;
    sb_check(64'(stall));
    rd_en = 2'b00;
    wr_en = 1'b1; wr_addr = a5(4); wr_data = 32'h4444;
    tick();
    wr_en = 1'b0;
    exp_push("r4_busy_clr", 64'h0);
    #1;
    sb_check(64'(busy));

    // Debug tap: one-cycle latency, no forwarding.
    wr_en = 1'b1; wr_addr = a5(3); wr_data = 32'h55;
    tick();
    wr_en = 1'b0; dbg_sel = a5(3);
    exp_push("dbg_pre", 64'h0);
    #1;
    sb_check(64'(dbg_data));
    tick();
    exp_push("dbg_r3", 64'h55);
    #1;
    sb_check(64'(dbg_data));
    wr_en = 1'b1; wr_addr = a5(3); wr_data = 32'h66;
    tick();
    wr_en = 1'b0;
    exp_push("dbg_nofwd", 64'h55);
    #1;
    sb_check(64'(dbg_data));
    tick();
    exp_push("dbg_new", 64'h66);
    #1;
    sb_check(64'(dbg_data));

    // Reset mid-operation discards busy[3] and a concurrent write/issue.
    iss_en = 1'b1; iss_addr = a5(3);
    tick();
    iss_en = 1'b0;
    exp_push("r3_busy", 64'h8);
    #1;
    sb_check(64'(busy));
    reset = 1'b1; wr_en = 1'b1; wr_addr = a5(3); wr_data = 32'h77; iss_en = 1'b1; iss_addr = a5(8);
    tick();
    reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0; rd_addr = {a5(8), a5(3)};
    exp_push("mid_rst_busy", 64'h0);
    exp_push("mid_rst_rd", 64'h0);
    exp_push("mid_rst_dbg", 64'h0);
    #1;
    sb_check(64'(busy));
    sb_check(64'(rd_data));
    sb_check(64'(dbg_data));
    tick();
    exp_push("post_rst_dbg", 64'h0);
    #1;
    sb_check(64'(dbg_data));

    if (vq.size() != 0) begin
      n_checks++;
      $error("FAIL sb_leftover observed=%0d expected=0", vq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
